// File: rtl/parity_frame_tx_if.sv
// Byte handshake between the upstream parity generator and the frame transmitter.
interface parity_frame_tx_if;
   logic [7:0] data_in;
   logic       parity_in;
   logic       valid_in;
   logic       ready_out;

   modport master (
      output data_in,
      output parity_in,
      output valid_in,
      input  ready_out
   );

   modport slave (
      input  data_in,
      input  parity_in,
      input  valid_in,
      output ready_out
   );
endinterface

// File: rtl/parity_frame_tx.sv
// Serial framer: start, 8 data bits LSB first, parity, stop; each bit held CLKS_PER_BIT cycles.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | start bit (0)
// DATA   | data bit bit_idx of the latched byte
// PARITY | latched parity bit
// STOP   | stop bit (1); frame_done pulses on exit
module parity_frame_tx #(
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_ODD   = 0
) (
   input  logic               clk,
   input  logic               rst,
   parity_frame_tx_if.slave   up,
   output logic               tx_out,
   output logic               busy,
   output logic               frame_done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic ODD_BIT = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cyc_cnt, cyc_nxt;
   logic [2:0]    bit_idx, idx_nxt;
   logic [7:0]    data_q;
   logic          par_q;
   logic          latch;
   logic          tx_nxt;
   logic          done_nxt;
   logic          last;

   assign last = (cyc_cnt == CYC_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cyc_cnt      <= '0;
         bit_idx      <= '0;
         data_q       <= '0;
         par_q        <= 1'b0;
         tx_out       <= 1'b1;
         up.ready_out <= 1'b1;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         state   <= state_nxt;
         cyc_cnt <= cyc_nxt;
         bit_idx <= idx_nxt;
         if (latch) begin
            data_q <= up.data_in;
            par_q  <= up.parity_in ^ ODD_BIT;
         end
         // outputs are registered from the next state so the line changes on the state edge
         tx_out       <= tx_nxt;
         up.ready_out <= (state_nxt == IDLE);
         busy         <= (state_nxt != IDLE);
         frame_done   <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cyc_nxt   = cyc_cnt;
      idx_nxt   = bit_idx;
      latch     = 1'b0;
      done_nxt  = 1'b0;

      if (state == IDLE) begin
         if (up.valid_in) begin
            latch     = 1'b1;
            state_nxt = START;
            cyc_nxt   = '0;
         end
      end else if (!last) begin
         cyc_nxt = cyc_cnt + CW'(1);
      end else begin
         cyc_nxt = '0;
         case (state)
            START: begin
               state_nxt = DATA;
               idx_nxt   = 3'd0;
            end
            DATA: begin
               idx_nxt = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nxt = PARITY;
            end
            PARITY: state_nxt = STOP;
            STOP: begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end

      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = data_q[idx_nxt];
         PARITY:  tx_nxt = par_q;
         default: tx_nxt = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx: table of frames over three configurations plus reset/back-to-back sequences.
module tb_parity_frame_tx;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] data_bus = 8'h00;
   logic       par_bus  = 1'b0;
   logic       valid_v [3];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   parity_frame_tx_if if_e();
   parity_frame_tx_if if_o();
   parity_frame_tx_if if_1();

   assign if_e.data_in = data_bus;  assign if_e.parity_in = par_bus;  assign if_e.valid_in = valid_v[0];
   assign if_o.data_in = data_bus;  assign if_o.parity_in = par_bus;  assign if_o.valid_in = valid_v[1];
   assign if_1.data_in = data_bus;  assign if_1.parity_in = par_bus;  assign if_1.valid_in = valid_v[2];

   logic tx_v [3];
   logic busy_v [3];
   logic done_v [3];

   parity_frame_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(0)) dut_e (
      .clk(clk), .rst(rst), .up(if_e.slave),
      .tx_out(tx_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));
   parity_frame_tx #(.CLKS_PER_BIT(4), .PARITY_ODD(1)) dut_o (
      .clk(clk), .rst(rst), .up(if_o.slave),
      .tx_out(tx_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));
   parity_frame_tx #(.CLKS_PER_BIT(1), .PARITY_ODD(0)) dut_1 (
      .clk(clk), .rst(rst), .up(if_1.slave),
      .tx_out(tx_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

   function automatic logic get_ready(input int id);
      case (id)
         0:       return if_e.ready_out;
         1:       return if_o.ready_out;
         default: return if_1.ready_out;
      endcase
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_idle(input string name, input int id);
      chk({name, "_tx"},    tx_v[id],      1'b1);
      chk({name, "_ready"}, get_ready(id), 1'b1);
      chk({name, "_busy"},  busy_v[id],    1'b0);
      chk({name, "_done"},  done_v[id],    1'b0);
   endtask

   // Sends one byte and checks every cycle of the frame against the hand-given expected frame.
   task automatic run_frame(input string name, input int id, input int n,
                            input logic [7:0] d, input logic p, input logic exp_p,
                            input bit hold);
      logic [10:0] exp_frame;
      int t;
      exp_frame = {1'b1, exp_p, d, 1'b0};
      t = 0;
      while (get_ready(id) !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      n_checks++;
      if (t >= 200) begin
         n_errors++;
         $display("FAIL %s_wait_ready: got ready=%b expected 1 within 200 cycles", name, get_ready(id));
      end
      data_bus    = d;
      par_bus     = p;
      valid_v[id] = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) valid_v[id] = 1'b0;
      for (int j = 0; j < 11 * n; j++) begin
         @(negedge clk);
         chk($sformatf("%s_tx_c%0d", name, j), tx_v[id], exp_frame[j / n]);
         chk($sformatf("%s_ready_c%0d", name, j), get_ready(id), 1'b0);
         chk($sformatf("%s_busy_c%0d", name, j), busy_v[id], 1'b1);
         chk($sformatf("%s_done_c%0d", name, j), done_v[id], 1'b0);
         if (j == 2) begin
            data_bus = ~d;
            par_bus  = ~p;
         end
      end
      @(negedge clk);
      chk({name, "_end_tx"},    tx_v[id],      1'b1);
      chk({name, "_end_ready"}, get_ready(id), 1'b1);
      chk({name, "_end_busy"},  busy_v[id],    1'b0);
      chk({name, "_end_done"},  done_v[id],    1'b1);
      if (!hold) begin
         @(negedge clk);
         chk({name, "_done_clear"}, done_v[id], 1'b0);
         chk({name, "_idle_tx"},    tx_v[id],   1'b1);
      end
   endtask

   typedef struct {
      string      name;
      int         id;
      int         n;
      logic [7:0] data;
      logic       par;
      logic       exp_par;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{"zero_byte",   0, 4, 8'h00, 1'b0, 1'b0};
      vecs[1] = '{"byte_01",     0, 4, 8'h01, 1'b1, 1'b1};
      vecs[2] = '{"byte_aa",     0, 4, 8'hAA, 1'b0, 1'b0};
      vecs[3] = '{"odd_ff",      1, 4, 8'hFF, 1'b0, 1'b1};
      vecs[4] = '{"odd_01",      1, 4, 8'h01, 1'b1, 1'b0};
      vecs[5] = '{"n1_5a",       2, 1, 8'h5A, 1'b0, 1'b0};
      vecs[6] = '{"bad_par_c3",  0, 4, 8'hC3, 1'b1, 1'b1};

      // Reset with valid asserted: nothing may start.
      for (int i = 0; i < 3; i++) valid_v[i] = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) chk_idle($sformatf("reset_c%0d_d%0d", c, i), i);
      end
      for (int i = 0; i < 3; i++) valid_v[i] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk_idle($sformatf("post_reset_d%0d", i), i);

      for (int v = 0; v < 7; v++)
         run_frame(vecs[v].name, vecs[v].id, vecs[v].n, vecs[v].data,
                   vecs[v].par, vecs[v].exp_par, 1'b0);

      // Back-to-back with valid held: second start edge lands at E0+45.
      run_frame("b2b_first",  0, 4, 8'h03, 1'b0, 1'b0, 1'b1);
      run_frame("b2b_second", 0, 4, 8'h00, 1'b0, 1'b0, 1'b0);

      // N=1 back-to-back: period of 12 cycles.
      run_frame("n1_b2b_first",  2, 1, 8'h81, 1'b0, 1'b0, 1'b1);
      run_frame("n1_b2b_second", 2, 1, 8'h7E, 1'b0, 1'b0, 1'b0);

      // Reset during data bit 3 of 8'hF7 (bit 3 is 0).
      data_bus   = 8'hF7;
      par_bus    = 1'b1;
      valid_v[0] = 1'b1;
      @(posedge clk);
      #1;
      valid_v[0] = 1'b0;
      for (int j = 0; j < 18; j++) @(negedge clk);
      chk("midrst_before_tx",   tx_v[0],   1'b0);
      chk("midrst_before_busy", busy_v[0], 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk_idle("midrst_abort", 0);
      rst = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         chk($sformatf("midrst_quiet_done_c%0d", c), done_v[0], 1'b0);
         chk($sformatf("midrst_quiet_tx_c%0d", c),   tx_v[0],   1'b1);
      end
      run_frame("after_reset_3c", 0, 4, 8'h3C, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
